// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler and its RX/TX neighbours.
package uart_tx_scheduler_pkg;

  // One bit time at 27 MHz / 115200 baud, in clk cycles.
  localparam int DELAY_FRAMES = 234;

  // Scheduler FSM encodings.
  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_STREAM = 2'd1,
    SCHED_GAP    = 2'd2
  } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and transmitter-side handshake bundle for the UART transmit scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 trunc_err;

  // Environment side: message sources and the byte transmitter.
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, busy, trunc_err
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant, busy, trunc_err
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at or above rr_ptr, wrapping back to 0.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [PTR_W-1:0]   pick_idx,
  output logic               any_req
);

  int   idx;
  logic found;

  // Search NUM_REQ slots starting at rr_ptr; the wrap is explicit so non-power-of-2 counts work.
  always_comb begin
    // NOTE: every variable gets a default before the search so no latch is inferred.
    pick_onehot = '0;
    pick_idx    = '0;
    any_req     = |req;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[PTR_W'(idx)]) begin
        found                     = 1'b1;
        pick_idx                  = PTR_W'(idx);
        pick_onehot[PTR_W'(idx)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter among NUM_REQ sources: whole-message round-robin grants,
// combinational byte pass-through from the owner, and an idle gap after every message.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int GAP_CYCLES  = DELAY_FRAMES,
  parameter int MAX_MSG_LEN = 16
) (
  input logic                clk,
  input logic                rst_n,
  uart_tx_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [7:0]       LIMIT    = 8'(MAX_MSG_LEN - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_CYCLES);

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               trunc_err_q, trunc_err_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               any_req;
  logic               tx_valid_c;
  logic [7:0]         tx_data_c;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [7:0]         req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = bus.req_data[8*g +: 8];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (bus.req_valid),
    .rr_ptr      (rr_ptr_q),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .any_req     (any_req)
  );

  // Next-state logic and owner pass-through; bytes only move while streaming.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    trunc_err_d = trunc_err_q;
    tx_valid_c  = 1'b0;
    tx_data_c   = '0;
    req_ready_c = '0;
    unique case (state_q)
      SCHED_IDLE: begin
        if (any_req) begin
          grant_d    = pick_onehot;
          owner_d    = pick_idx;
          byte_cnt_d = '0;
          state_d    = SCHED_STREAM;
        end
      end
      SCHED_STREAM: begin
        tx_valid_c           = bus.req_valid[owner_q];
        tx_data_c            = req_bytes[owner_q];
        req_ready_c[owner_q] = bus.tx_ready;
        if (tx_valid_c && bus.tx_ready) begin
          byte_cnt_d = byte_cnt_q + 8'd1;
          // A last byte always wins over the length limit, so trunc_err only flags real cuts.
          if (bus.req_last[owner_q] || byte_cnt_q == LIMIT) begin
            rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
            grant_d  = '0;
            state_d  = (GAP_CYCLES > 0) ? SCHED_GAP : SCHED_IDLE;
            if (!bus.req_last[owner_q]) trunc_err_d = 1'b1;
          end
        end
      end
      SCHED_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_d == GAP_END) begin
          gap_cnt_d = '0;
          state_d   = SCHED_IDLE;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCHED_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      trunc_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;
  assign bus.req_ready = req_ready_c;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != SCHED_IDLE);
  assign bus.trunc_err = trunc_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: directed messages, expected bytes queued in hand-derived order.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 2;
  localparam int GAP     = 234;
  localparam int MAXL    = 16;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct packed {
    logic [7:0] src;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .GAP_CYCLES  (GAP),
    .MAX_MSG_LEN (MAXL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  beat_t src0_q[$];
  beat_t src1_q[$];
  exp_t  exp_q[$];
  int    n_cmp   = 0;
  int    n_err   = 0;
  int    tx_mode = 0;  // 0: always ready, 1: one cycle in GAP, 2: stalled
  int    tick    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input int src, input string s, input bit with_last);
    beat_t b;
    for (int i = 0; i < s.len(); i++) begin
      b.data = s[i];
      b.last = with_last && (i == s.len() - 1);
      if (src == 0) src0_q.push_back(b);
      else          src1_q.push_back(b);
    end
  endtask

  task automatic expect_msg(input int src, input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.src  = 8'(src);
      e.data = s[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    bus.req_valid[0]   = (src0_q.size() > 0);
    bus.req_data[7:0]  = (src0_q.size() > 0) ? src0_q[0].data : 8'h00;
    bus.req_last[0]    = (src0_q.size() > 0) ? src0_q[0].last : 1'b0;
    bus.req_valid[1]   = (src1_q.size() > 0);
    bus.req_data[15:8] = (src1_q.size() > 0) ? src1_q[0].data : 8'h00;
    bus.req_last[1]    = (src1_q.size() > 0) ? src1_q[0].last : 1'b0;
    bus.tx_ready       = (tx_mode == 0) ? 1'b1 : (tx_mode == 1) ? (tick == 0) : 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0 || bus.busy)
           && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({name, "_done_in_budget"}, 32'(c < budget), 1);
  endtask

  task automatic wait_grant(input string name, input logic [1:0] g, input int budget);
    int c = 0;
    while (bus.grant != g && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({name, "_grant_in_budget"}, 32'(c < budget), 1);
  endtask

  // Source models: pop a byte when it was accepted at this edge, then present the next one.
  always @(posedge clk) begin
    logic [NUM_REQ-1:0] fire;
    fire = bus.req_valid & bus.req_ready;
    #1;
    if (fire[0] && src0_q.size() > 0) void'(src0_q.pop_front());
    if (fire[1] && src1_q.size() > 0) void'(src1_q.pop_front());
    tick = (tick == GAP - 1) ? 0 : tick + 1;
    drive();
  end

  // Monitor: every byte the transmitter takes must be the next expected one from the right owner.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_tx: got %0h expected nothing at %0t", bus.tx_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", 32'(bus.tx_data), 32'(e.data));
        check("tx_owner", 32'(bus.grant), 32'(1) << e.src);
        check("req_ready_owner_only", 32'(bus.req_ready), 32'(1) << e.src);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_trunc_err", 32'(bus.trunc_err), 0);
    rst_n = 1'b1;

    // Reset mid-stream: stalled transmitter holds the message in STREAM.
    tx_mode = 2;
    send(0, "RS", 1);
    wait_grant("midrst", 2'b01, 20);
    @(negedge clk);
    check("midrst_tx_valid_before", 32'(bus.tx_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_grant", 32'(bus.grant), 0);
    check("midrst_tx_valid", 32'(bus.tx_valid), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    src0_q.delete();
    tx_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_trunc_err", 32'(bus.trunc_err), 0);

    // Contention with rr_ptr=0: req0 first, then req1; rr_ptr wraps back to 0.
    send(0, "AB", 1);
    send(1, "xy", 1);
    expect_msg(0, "AB");
    expect_msg(1, "xy");
    wait_drain("pair1", 2000);
    send(0, "CD", 1);
    send(1, "zw", 1);
    expect_msg(0, "CD");
    expect_msg(1, "zw");
    wait_drain("pair2", 2000);
    // Lone req0 message moves rr_ptr to 1, so the next pair favours req1.
    send(0, "E", 1);
    expect_msg(0, "E");
    wait_drain("lone", 2000);
    send(0, "FG", 1);
    send(1, "uv", 1);
    expect_msg(1, "uv");
    expect_msg(0, "FG");
    wait_drain("pair3", 2000);

    // Single source with slow transmitter, then exactly GAP busy cycles.
    tx_mode = 1;
    send(0, "Lushay Labs ", 1);
    expect_msg(0, "Lushay Labs ");
    wait_grant("lushay_start", 2'b01, 20);
    wait_grant("lushay_end", 2'b00, 5000);
    check("lushay_all_sent", 32'(exp_q.size()), 0);
    cnt = 0;
    while (bus.busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("lushay_gap_cycles", 32'(cnt), 32'(GAP));
    check("lushay_idle_grant", 32'(bus.grant), 0);

    // No interleave: req1 rises while req0 owns the transmitter.
    send(0, "123", 1);
    expect_msg(0, "123");
    wait_grant("ilv_start", 2'b01, 20);
    send(1, "q", 1);
    expect_msg(1, "q");
    repeat (2) @(negedge clk);
    check("ilv_req1_valid", 32'(bus.req_valid[1]), 1);
    cnt = 0;
    while (bus.grant == 2'b01 && cnt < 1000) begin
      check("ilv_req_ready1", 32'(bus.req_ready[1]), 0);
      cnt++;
      @(negedge clk);
    end
    tx_mode = 0;
    wait_drain("ilv", 3000);

    // Last byte coincides with the length limit: normal release.
    send(0, "0123456789abcdef", 1);
    expect_msg(0, "0123456789abcdef");
    wait_drain("limit_last", 2000);
    check("limit_last_trunc_err", 32'(bus.trunc_err), 0);

    // Truncation: 20-byte message is cut after 16 and finishes under a new grant.
    send(0, "ABCDEFGHIJKLMNOPQRST", 1);
    expect_msg(0, "ABCDEFGHIJKLMNOPQRST");
    cnt = 0;
    while (exp_q.size() > 4 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    @(negedge clk);
    check("trunc_grant_dropped", 32'(bus.grant), 0);
    check("trunc_in_gap", 32'(bus.busy), 1);
    check("trunc_err_set", 32'(bus.trunc_err), 1);
    check("trunc_pending", 32'(exp_q.size()), 4);
    wait_drain("trunc", 2000);
    check("trunc_err_sticky", 32'(bus.trunc_err), 1);

    // Backpressure: transmitter stalled for 1000 cycles with a byte offered.
    tx_mode = 2;
    send(0, "XYZ", 1);
    expect_msg(0, "XYZ");
    wait_grant("stall_start", 2'b01, 20);
    @(negedge clk);
    repeat (1000) begin
      check("stall_tx_valid", 32'(bus.tx_valid), 1);
      check("stall_tx_data", 32'(bus.tx_data), 32'h58);
      check("stall_req_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
    end
    tx_mode = 0;
    wait_drain("stall", 2000);

    check("final_trunc_err", 32'(bus.trunc_err), 1);
    check("final_scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
